iomem_arbiter_ctrl: RTL

- Sequences every PicoSoC iomem transaction onto one of N_SLAVES memory-mapped peripherals (switch read port, GPIO/LED register, button read port, and later additions).
- Decodes the address, drives a per-slave valid, and returns the selected slave's ready/rdata to the CPU.
- Guarantees the CPU never stalls: unmapped addresses and unresponsive slaves get an error response, and the error is logged in sticky status registers.
- Sits between picosoc_noflash's iomem port and the peripheral registers in the board top.

---
 rtl/iomem_ic_pkg.sv | 28 ++
 rtl/iomem_addr_decode.sv | 26 ++
 rtl/iomem_arbiter_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/iomem_ic_pkg.sv
// Shared types for the iomem interconnect: FSM states, error causes and the latched request.
package iomem_ic_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    localparam logic [DATA_W-1:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_UNMAPPED = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } err_cause_t;

    typedef struct packed {
        logic [STRB_W-1:0] wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/iomem_addr_decode.sv
// Maps an iomem address onto a slot index; slot i covers BASE_ADDR + i*(1<<SLOT_SHIFT).
module iomem_addr_decode
    import iomem_ic_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0000_2000,
    parameter int unsigned       SLOT_SHIFT = 12,
    parameter int unsigned       N_SLAVES   = 3,
    parameter int unsigned       IDX_W      = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
    input  logic [ADDR_W-1:0] m_addr,
    output logic [IDX_W-1:0]  idx,
    output logic              mapped
);

    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] idx_full;

    // Full-width index so addresses far above the window never alias into a slot.
    always_comb begin
        off      = m_addr - BASE_ADDR;
        idx_full = off >> SLOT_SHIFT;
        mapped   = (m_addr >= BASE_ADDR) && (idx_full < ADDR_W'(N_SLAVES));
        idx      = IDX_W'(idx_full);
    end

endmodule

// File: rtl/iomem_arbiter_ctrl.sv
// Routes each CPU iomem transaction to one slave slot; unmapped or silent slaves get an error reply.
module iomem_arbiter_ctrl
    import iomem_ic_pkg::*;
#(
    parameter int unsigned       N_SLAVES   = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0000_2000,
    parameter int unsigned       SLOT_SHIFT = 12,
    parameter int unsigned       TIMEOUT    = 16,
    parameter logic [DATA_W-1:0] ERR_DATA   = DEFAULT_ERR_DATA
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       m_valid,
    output logic                       m_ready,
    input  logic [STRB_W-1:0]          m_wstrb,
    input  logic [ADDR_W-1:0]          m_addr,
    input  logic [DATA_W-1:0]          m_wdata,
    output logic [DATA_W-1:0]          m_rdata,
    output logic [N_SLAVES-1:0]        s_valid,
    input  logic [N_SLAVES-1:0]        s_ready,
    output logic [STRB_W-1:0]          s_wstrb,
    output logic [ADDR_W-1:0]          s_addr,
    output logic [DATA_W-1:0]          s_wdata,
    input  logic [DATA_W*N_SLAVES-1:0] s_rdata,
    input  logic                       err_clr,
    output logic                       err_flag,
    output logic [1:0]                 err_cause,
    output logic [ADDR_W-1:0]          err_addr
);

    localparam int unsigned IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    req_t               req_q, req_d;
    logic               m_ready_q, m_ready_d;
    logic [DATA_W-1:0]  m_rdata_q, m_rdata_d;
    logic [N_SLAVES-1:0] s_valid_q, s_valid_d;
    logic               err_flag_q, err_flag_d;
    err_cause_t         err_cause_q, err_cause_d;
    logic [ADDR_W-1:0]  err_addr_q, err_addr_d;

    logic [IDX_W-1:0]   dec_idx;
    logic               dec_mapped;
    logic               sel_ready;
    logic [DATA_W-1:0]  sel_rdata;

    iomem_addr_decode #(
        .BASE_ADDR  (BASE_ADDR),
        .SLOT_SHIFT (SLOT_SHIFT),
        .N_SLAVES   (N_SLAVES),
        .IDX_W      (IDX_W)
    ) u_decode (
        .m_addr (m_addr),
        .idx    (dec_idx),
        .mapped (dec_mapped)
    );

    // Ready/rdata of the latched slot only; other slots' ready lines are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < int'(N_SLAVES); i++) begin
            if (sel_q == IDX_W'(i)) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rdata[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        m_ready_d   = 1'b0;
        m_rdata_d   = m_rdata_q;
        s_valid_d   = s_valid_q;
        err_flag_d  = err_clr ? 1'b0 : err_flag_q;
        err_cause_d = err_clr ? ERR_NONE : err_cause_q;
        err_addr_d  = err_addr_q;

        unique case (state_q)
            IDLE: begin
                s_valid_d = '0;
                if (m_valid) begin
                    if (dec_mapped) begin
                        req_d     = '{wstrb: m_wstrb, addr: m_addr, wdata: m_wdata};
                        sel_d     = dec_idx;
                        s_valid_d = N_SLAVES'(1) << dec_idx;
                        cnt_d     = '0;
                        state_d   = WAIT;
                    end else begin
                        m_ready_d   = 1'b1;
                        m_rdata_d   = ERR_DATA;
                        err_flag_d  = 1'b1;
                        err_cause_d = ERR_UNMAPPED;
                        err_addr_d  = m_addr;
                        state_d     = RESP;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Slave completion takes priority over a coincident timeout.
                if (sel_ready) begin
                    m_ready_d = 1'b1;
                    m_rdata_d = sel_rdata;
                    s_valid_d = '0;
                    state_d   = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    m_ready_d   = 1'b1;
                    m_rdata_d   = ERR_DATA;
                    s_valid_d   = '0;
                    err_flag_d  = 1'b1;
                    err_cause_d = ERR_TIMEOUT;
                    err_addr_d  = req_q.addr;
                    state_d     = RESP;
                end
            end
            RESP: begin
                s_valid_d = '0;
                state_d   = IDLE;
            end
            default: begin
                s_valid_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            req_q       <= '0;
            m_ready_q   <= 1'b0;
            m_rdata_q   <= '0;
            s_valid_q   <= '0;
            err_flag_q  <= 1'b0;
            err_cause_q <= ERR_NONE;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            m_ready_q   <= m_ready_d;
            m_rdata_q   <= m_rdata_d;
            s_valid_q   <= s_valid_d;
            err_flag_q  <= err_flag_d;
            err_cause_q <= err_cause_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign m_ready   = m_ready_q;
    assign m_rdata   = m_rdata_q;
    assign s_valid   = s_valid_q;
    assign s_wstrb   = req_q.wstrb;
    assign s_addr    = req_q.addr;
    assign s_wdata   = req_q.wdata;
    assign err_flag  = err_flag_q;
    assign err_cause = err_cause_q;
    assign err_addr  = err_addr_q;

endmodule
